led_chaser_multi: RTL

//   Parametrised LED chaser for the board LED banks: built-in prescaler, run-time

---
 rtl/led_chaser_multi.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/led_chaser_multi.sv
// LED chaser with built-in prescaler, rotate/bounce/hold modes, pattern load and pause.
// Define LED_CHASER_TRAIL_EN to drive led_g with the previous led_r position; otherwise led_g is 0.
module led_chaser_multi #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       DIV_MAX = 1048576,
  parameter logic [WIDTH-1:0]  SEED    = WIDTH'(8'b1100_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pattern,
  output logic [WIDTH-1:0] led_r,
  output logic [WIDTH-1:0] led_g,
  output logic             step_out,
  output logic             ctl_bit
);

  localparam int unsigned    CW       = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV_MAX - 1);

  typedef enum logic [1:0] {
    MODE_ROR    = 2'b00,
    MODE_ROL    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  mode_e            mode_s;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pat_q, pat_d, pat_next;
  dir_e             dir_q, dir_d, dir_next;
  logic             step_q, step_d;
  logic             tick;

  assign mode_s = mode_e'(mode);
  assign tick   = enable && (count_q == CNT_LAST);

  // Pattern/direction that a tick would produce in the current mode.
  always_comb begin
    pat_next = pat_q;
    dir_next = dir_q;
    case (mode_s)
      MODE_ROR: pat_next = {pat_q[0], pat_q[WIDTH-1:1]};
      MODE_ROL: pat_next = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
      MODE_BOUNCE: begin
        if (pat_q[0] && pat_q[WIDTH-1]) begin
          pat_next = pat_q;
          dir_next = dir_q;
        end else if (dir_q == DIR_RIGHT) begin
          if (!pat_q[0]) begin
            pat_next = pat_q >> 1;
          end else begin
            pat_next = pat_q << 1;
            dir_next = DIR_LEFT;
          end
        end else begin
          if (!pat_q[WIDTH-1]) begin
            pat_next = pat_q << 1;
          end else begin
            pat_next = pat_q >> 1;
            dir_next = DIR_RIGHT;
          end
        end
      end
      default: pat_next = pat_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (load) begin
      pat_d   = load_pattern;
      count_d = '0;
      dir_d   = DIR_RIGHT;
    end else begin
      if (enable) begin
        count_d = tick ? '0 : count_q + 1'b1;
      end
      if (tick) begin
        pat_d  = pat_next;
        dir_d  = dir_next;
        step_d = 1'b1;
      end
    end
    // Leaving bounce mode always re-arms it to start moving right.
    if (mode_s != MODE_BOUNCE) begin
      dir_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      pat_q   <= SEED;
      dir_q   <= DIR_RIGHT;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

`ifdef LED_CHASER_TRAIL_EN
  logic [WIDTH-1:0] trail_q, trail_d;

  always_comb begin
    trail_d = trail_q;
    if (load) begin
      trail_d = '0;
    end else if (tick) begin
      trail_d = pat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trail_q <= '0;
    end else begin
      trail_q <= trail_d;
    end
  end

  assign led_g = trail_q;
`else
  assign led_g = '0;
`endif

  assign led_r    = pat_q;
  assign step_out = step_q;
  assign ctl_bit  = 1'b1;

endmodule
